dds_pwm_dac: RTL and testbench
==============================

Name: dds_pwm_dac

Overview:
- Output stage directly downstream of the DDS waveform generator.
- Accepts one DDS sample per PWM period over a valid/ready handshake and converts it into a single-bit PWM waveform for an external RC-filtered pin.
- Double-buffered: a pending register holds the next sample while the current duty value plays out.
- Missing samples at the period boundary are flagged as a sticky underrun.

Parameters:
- DATA_WIDTH, 8, sample width W; PWM period is 2^W clocks.
- SIGNED_IN, 0, 1 = input is two's complement and is converted to offset binary on acceptance (MSB inverted); 0 = input is already unsigned.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  run PWM counter; low = output idle
- sample_in  input  DATA_WIDTH  sample from DDS stage
- sample_valid  input  1  sample_in valid
- sample_ready  output  1  pending buffer can accept a sample (registered)
- pwm_out  output  1  PWM bit (registered)
- period_start  output  1  one-cycle pulse when a new period begins and duty is loaded
- underrun  output  1  sticky: period boundary reached with no sample available
- underrun_clear  input  1  clears underrun

Behaviour:
- Reset (reset=1 at a rising edge):
  - cnt=0, duty=0, pending_full=0, pending=0.
  - pwm_out=0, period_start=0, underrun=0, sample_ready=0.
  - sample_ready rises on the first cycle after reset deasserts.
  - Reset mid-period abandons the period immediately, with no partial output.
- Handshake:
  - Transfer occurs when sample_valid && sample_ready at a rising edge.
  - The accepted value (MSB-inverted if SIGNED_IN) goes to pending; pending_full<=1.
  - sample_ready is registered: sample_ready <= !pending_full_next, so at most one transfer occurs while the buffer is full.
  - sample_in is ignored when no transfer occurs.
- Counter:
  - cnt is W bits, increments by 1 each cycle while enable=1 and wraps from 2^W-1 to 0.
  - With enable=0: cnt<=0, pwm_out<=0, period_start<=0, no duty loads, no underrun detection.
  - Handshake still operates while enable=0, so the pending buffer fills once and then sample_ready drops.
- Load at wrap (enable=1 and cnt==2^W-1):
  - period_start<=1 on every wrap.
  - If pending_full: duty<=pending, pending_full<=0.
  - Else, if a transfer occurs in this same cycle: bypass, duty<=converted sample_in, pending stays empty, no underrun.
  - Else: duty holds its previous value and underrun<=1.
  - If pending_full and a transfer occurs in the same cycle: pending is loaded to duty and the new sample enters pending. This cannot happen with registered ready (ready=0 while full) and is listed for completeness.
- PWM compare:
  - pwm_out <= enable && (cnt < duty): unsigned compare, one-cycle latency from cnt.
  - duty=0 gives constant 0; duty=2^W-1 gives high for 2^W-1 of 2^W clocks (never 100%).
  - The first PWM period after enable rises uses the duty loaded at the first wrap. Before that, duty=0 (after reset) or the last value held.
- Underrun flag:
  - Set on a wrap with no data available; cleared by underrun_clear.
  - Set wins over clear when both occur in the same cycle.
  - Reset clears it.
- Widths: no arithmetic overflow beyond the cnt wrap; all compares are W-bit unsigned.

Test Plan:
- Duty 25% (W=8, SIGNED_IN=0): reset, enable=1, send 0x40 -> period_start pulse at cnt wrap; afterwards pwm_out is high exactly 64 of every 256 clocks; sample_ready returns to 1 after the load.
- Duty extremes: 0x00 -> pwm_out constantly 0; 0xFF -> pwm_out high 255 clocks, low 1 clock per period. Check across 3 periods with one sample per period.
- Underrun and flag behaviour: after one load, send nothing -> at next wrap underrun=1 and the previous duty repeats. Pulse underrun_clear on a non-wrap cycle -> 0. Clear on a wrap cycle with no data -> remains 1.
- Backpressure and bypass:
  - Send 0x10 and 0x20 back-to-back -> first fills pending, sample_ready=0 until the wrap loads 0x10; 0x20 is accepted the cycle after ready rises.
  - Separately, present a sample only on the cnt==255 cycle with pending empty -> bypassed to duty, no underrun.
- SIGNED_IN=1: inputs 0x80, 0x00, 0x7F -> duty 0x00, 0x80, 0xFF; high times 0, 128, 255 clocks.
- Enable and reset mid-operation:
  - Drop enable mid-period -> pwm_out=0 the next cycle, cnt=0, no period_start. A sample sent while disabled is held in pending; re-enable -> the sample loads at the first wrap.
  - Assert reset mid-period with pending_full=1 -> all outputs are at reset values the cycle after and the pending sample is discarded.

Source files
------------

// File: rtl/dds_pwm_dac.sv
// Purpose : PWM output stage behind the DDS generator; one sample per 2^W-clock
//           PWM period over valid/ready, double-buffered, sticky underrun flag.
// Latency : pwm_out follows the counter by 1 clock; a new duty takes effect at the wrap.
// Backpressure: sample_ready (registered) drops while the pending buffer is full.
//
// Ports:
//   clock          rising-edge system clock
//   reset          synchronous active-high reset
//   enable         runs the PWM counter; low forces the output idle
//   sample_in      DDS sample (two's complement when SIGNED_IN=1)
//   sample_valid   sample_in valid
//   sample_ready   pending buffer can take a sample
//   pwm_out        PWM bit toward the RC filter
//   period_start   one-cycle pulse when a period begins and duty is loaded
//   underrun       sticky: a period boundary found no sample available
//   underrun_clear clears underrun (a simultaneous new underrun wins)
module dds_pwm_dac #(
  parameter int DATA_WIDTH = 8,
  parameter bit SIGNED_IN  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic                  underrun,
  input  logic                  underrun_clear
);

  // Inverting the MSB maps two's complement onto offset binary, so the most
  // negative input becomes duty 0 and the most positive becomes full scale.
  localparam logic [DATA_WIDTH-1:0] MSB_ONE  = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MSB_FLIP = SIGNED_IN ? MSB_ONE : '0;
  localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;

  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_duty;
  logic [DATA_WIDTH-1:0] r_pending;
  logic                  r_pending_full;
  logic                  r_ready;
  logic                  r_pwm;
  logic                  r_period_start;
  logic                  r_underrun;

  logic                  w_xfer;
  logic                  w_wrap;
  logic [DATA_WIDTH-1:0] w_conv;
  logic [DATA_WIDTH-1:0] w_duty_nxt;
  logic [DATA_WIDTH-1:0] w_pending_nxt;
  logic                  w_pending_full_nxt;
  logic                  w_load_miss;

  assign w_xfer = sample_valid && r_ready;
  assign w_conv = sample_in ^ MSB_FLIP;
  // The last clock of a period; only meaningful while the counter runs.
  assign w_wrap = enable && (r_cnt == CNT_MAX);

  // Buffer/duty update. At the wrap the pending sample has priority; with an
  // empty buffer a sample arriving on that very clock bypasses straight into
  // duty so an exactly-on-time producer never triggers an underrun.
  always_comb begin
    w_duty_nxt         = r_duty;
    w_pending_nxt      = r_pending;
    w_pending_full_nxt = r_pending_full;
    w_load_miss        = 1'b0;
    if (w_wrap) begin
      if (r_pending_full) begin
        w_duty_nxt         = r_pending;
        w_pending_full_nxt = w_xfer;
        if (w_xfer) begin
          w_pending_nxt = w_conv;
        end
      end else if (w_xfer) begin
        w_duty_nxt         = w_conv;
        w_pending_full_nxt = 1'b0;
      end else begin
        w_load_miss = 1'b1;
      end
    end else if (w_xfer) begin
      w_pending_nxt      = w_conv;
      w_pending_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt          <= '0;
      r_duty         <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_ready        <= 1'b0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      r_duty         <= w_duty_nxt;
      r_pending      <= w_pending_nxt;
      r_pending_full <= w_pending_full_nxt;
      // Ready looks at the next buffer state, so a full buffer never sees a
      // second transfer.
      r_ready        <= !w_pending_full_nxt;
      r_period_start <= w_wrap;
      if (enable) begin
        r_cnt <= r_cnt + DATA_WIDTH'(1);
        // Compare uses the duty in force now; at the wrap clock cnt is the
        // maximum, so the output is low there for any duty (never 100%).
        r_pwm <= (r_cnt < r_duty);
      end else begin
        r_cnt <= '0;
        r_pwm <= 1'b0;
      end
      if (w_load_miss) begin
        r_underrun <= 1'b1;
      end else if (underrun_clear) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign sample_ready = r_ready;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_dds_pwm_dac.sv
// Purpose : bench for dds_pwm_dac (unsigned and signed instances, W=8).
// Latency : expectations are queued per period_start and checked by a monitor.
// Backpressure: stimulus waits on sample_ready with bounded loops.
module tb_dds_pwm_dac;

  logic       clock;
  logic       reset;
  logic       clr;
  logic       en_u, en_s;
  logic [7:0] in_u, in_s;
  logic       vld_u, vld_s;
  logic       rdy_u, rdy_s;
  logic       pwm_u, pwm_s;
  logic       ps_u, ps_s;
  logic       ur_u, ur_s;

  dds_pwm_dac #(.DATA_WIDTH(8), .SIGNED_IN(1'b0)) dut_u (
    .clock(clock), .reset(reset), .enable(en_u), .sample_in(in_u),
    .sample_valid(vld_u), .sample_ready(rdy_u), .pwm_out(pwm_u),
    .period_start(ps_u), .underrun(ur_u), .underrun_clear(clr)
  );

  dds_pwm_dac #(.DATA_WIDTH(8), .SIGNED_IN(1'b1)) dut_s (
    .clock(clock), .reset(reset), .enable(en_s), .sample_in(in_s),
    .sample_valid(vld_s), .sample_ready(rdy_s), .pwm_out(pwm_s),
    .period_start(ps_s), .underrun(ur_s), .underrun_clear(clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] duty;
    logic       ur;
  } exp_t;

  exp_t       q_u[$];
  exp_t       q_s[$];
  exp_t       mon_e;
  int         acc[2];
  bit         meas[2];
  bit         have[2];
  logic [7:0] exp_duty[2];

  logic [1:0] en_w, ps_w, pwm_w, ur_w;
  assign en_w  = {en_s, en_u};
  assign ps_w  = {ps_s, ps_u};
  assign pwm_w = {pwm_s, pwm_u};
  assign ur_w  = {ur_s, ur_u};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic ur);
    exp_t e;
    e.duty = d;
    e.ur   = ur;
    if (k == 0) q_u.push_back(e);
    else        q_s.push_back(e);
  endtask

  task automatic wait_ps(input int k);
    int b = 0;
    do begin
      go(1);
      b++;
    end while (((k == 0) ? ps_u : ps_s) !== 1'b1 && b < 600);
    if (b >= 600) fail_msg("wait_ps timeout: no period_start within 600 cycles");
  endtask

  task automatic send(input int k, input logic [7:0] v);
    int b = 0;
    if (k == 0) begin in_u = v; vld_u = 1'b1; end
    else        begin in_s = v; vld_s = 1'b1; end
    while (((k == 0) ? rdy_u : rdy_s) !== 1'b1 && b < 600) begin
      go(1);
      b++;
    end
    if (b >= 600) fail_msg("send timeout: sample_ready never rose");
    go(1);
    vld_u = 1'b0;
    vld_s = 1'b0;
  endtask

  // One sample during the current period; it becomes the next period's duty.
  task automatic per(input int k, input logic [7:0] v, input logic [7:0] d);
    send(k, v);
    push(k, d, 1'b0);
    wait_ps(k);
  endtask

  // Monitor: at each period_start, the high count of the finished period is
  // checked against the duty expected for it, and the next expectation is
  // popped (underrun state checked immediately).
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (reset || !en_w[k]) begin
        meas[k] = 1'b0;
        have[k] = 1'b0;
      end else if (ps_w[k]) begin
        if (meas[k] && have[k])
          chk((k == 0) ? "high_clocks_u" : "high_clocks_s", acc[k], {24'd0, exp_duty[k]});
        if (((k == 0) ? q_u.size() : q_s.size()) == 0) begin
          fail_msg((k == 0) ? "unexpected period_start u" : "unexpected period_start s");
          have[k] = 1'b0;
        end else begin
          if (k == 0) mon_e = q_u.pop_front();
          else        mon_e = q_s.pop_front();
          chk((k == 0) ? "underrun_at_start_u" : "underrun_at_start_s", {31'd0, ur_w[k]}, {31'd0, mon_e.ur});
          exp_duty[k] = mon_e.duty;
          have[k]     = 1'b1;
        end
        acc[k]  = 0;
        meas[k] = 1'b1;
      end else begin
        acc[k] += int'(pwm_w[k]);
      end
    end
  end

  initial begin
    int w;
    reset = 1'b1; clr = 1'b0;
    en_u = 1'b0; en_s = 1'b0;
    in_u = 8'h00; in_s = 8'h00;
    vld_u = 1'b0; vld_s = 1'b0;

    // Reset values
    go(3);
    chk("rst_pwm", pwm_u, 0);
    chk("rst_period_start", ps_u, 0);
    chk("rst_underrun", ur_u, 0);
    chk("rst_ready_u", rdy_u, 0);
    chk("rst_ready_s", rdy_s, 0);
    reset = 1'b0;
    go(1);
    chk("ready_after_reset", rdy_u, 1);

    // 25% duty, then extremes
    en_u = 1'b1;
    send(0, 8'h40);
    push(0, 8'h40, 1'b0);
    wait_ps(0);
    chk("ready_after_load", rdy_u, 1);
    per(0, 8'h40, 8'h40);
    per(0, 8'h00, 8'h00);
    per(0, 8'h00, 8'h00);
    per(0, 8'h00, 8'h00);
    per(0, 8'hFF, 8'hFF);
    per(0, 8'hFF, 8'hFF);
    per(0, 8'hFF, 8'hFF);

    // Underrun: previous duty repeats; clear off-wrap works, clear on a dry wrap loses
    push(0, 8'hFF, 1'b1);
    wait_ps(0);
    clr = 1'b1;
    go(1);
    clr = 1'b0;
    chk("underrun_cleared", ur_u, 0);
    go(254);
    clr = 1'b1;
    push(0, 8'hFF, 1'b1);
    go(1);
    clr = 1'b0;
    chk("wrap_ps", ps_u, 1);
    chk("set_beats_clear", ur_u, 1);
    clr = 1'b1;
    go(1);
    clr = 1'b0;

    // Backpressure: 0x10 fills pending, 0x20 waits for the load
    vld_u = 1'b1;
    in_u  = 8'h10;
    go(1);
    in_u = 8'h20;
    chk("bp_ready_low", rdy_u, 0);
    push(0, 8'h10, 1'b0);
    w = 0;
    while (rdy_u !== 1'b1 && w < 600) begin
      go(1);
      w++;
    end
    chk("bp_wait_cycles", w, 254);
    chk("bp_ready_with_load", ps_u, 1);
    go(1);
    vld_u = 1'b0;
    chk("bp_second_accepted", rdy_u, 0);
    push(0, 8'h20, 1'b0);
    wait_ps(0);

    // Bypass: sample only on the cnt==255 clock
    go(255);
    vld_u = 1'b1;
    in_u  = 8'h30;
    push(0, 8'h30, 1'b0);
    go(1);
    vld_u = 1'b0;
    chk("bypass_ps", ps_u, 1);
    chk("bypass_no_underrun", ur_u, 0);
    chk("bypass_ready", rdy_u, 1);
    per(0, 8'h08, 8'h08);

    // Enable dropped mid-period, sample held while disabled
    go(100);
    en_u = 1'b0;
    go(1);
    chk("dis_pwm", pwm_u, 0);
    chk("dis_ps", ps_u, 0);
    send(0, 8'h50);
    go(3);
    chk("dis_pending_held", rdy_u, 0);
    en_u = 1'b1;
    go(255);
    chk("reen_no_early_ps", ps_u, 0);
    push(0, 8'h50, 1'b0);
    go(1);
    chk("reen_ps_at_256", ps_u, 1);
    per(0, 8'h60, 8'h60);

    // Reset mid-period with a full pending buffer
    go(10);
    send(0, 8'h70);
    go(10);
    chk("pre_reset_pwm", pwm_u, 1);
    reset = 1'b1;
    go(1);
    chk("mid_rst_pwm", pwm_u, 0);
    chk("mid_rst_ps", ps_u, 0);
    chk("mid_rst_underrun", ur_u, 0);
    chk("mid_rst_ready", rdy_u, 0);
    reset = 1'b0;
    push(0, 8'h00, 1'b1);
    wait_ps(0);
    push(0, 8'h00, 1'b1);
    wait_ps(0);
    go(1);
    en_u = 1'b0;

    // Signed input: 0x80/0x00/0x7F -> duty 0x00/0x80/0xFF
    en_s = 1'b1;
    per(1, 8'h80, 8'h00);
    per(1, 8'h00, 8'h80);
    per(1, 8'h7F, 8'hFF);
    per(1, 8'h7F, 8'hFF);
    go(1);
    en_s = 1'b0;
    go(2);

    chk("queue_u_drained", q_u.size(), 0);
    chk("queue_s_drained", q_s.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
